// File: rtl/demux_pkg.sv
// Shared definitions for the TDM 1-to-N demultiplexer: FSM states,
// default lane count and the parity reduction helper.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int DEMUX_LANES = 8;

    // Zero-extended callers are fine: padding zeros do not change the XOR.
    function automatic logic xor_reduce(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot counter for the TDM demultiplexer. Clear has priority over
// load-to-1, which has priority over increment. Increment wraps modulo 2^W.
// tc flags the final slot of a frame.
module demux_slot_ctr #(
    parameter int W    = 3,
    parameter int LAST = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld1,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Slot register with prioritised clear / load-to-1 / increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld1) begin
            cnt <= W'(1);
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/demux_1x8_tdm.sv
// Receiving end of a serialised LANES-wide bus. Bits are steered into an
// assembly register by slot and completed frames are handed out through a
// valid/ready output register.
// Optional feature macro: DEMUX_PARITY_EN adds a trailing even-parity slot
// and drives parity_err; without it the frame is LANES slots and
// parity_err stays 0.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first sof; bits without sof are dropped
// FILL  | assembling a frame, next bit goes to slot sel
// STALL | frame complete but output register occupied; din_ready=0
module demux_1x8_tdm
    import demux_pkg::*;
#(
    parameter int LANES = DEMUX_LANES,
    parameter int SEL_W = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic             din_ready,
    output logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sync_err,
    output logic             parity_err
);

`ifdef DEMUX_PARITY_EN
    localparam int FRAME = LANES + 1;
    localparam int CW    = SEL_W + 1;
`else
    localparam int FRAME = LANES;
    localparam int CW    = SEL_W;
`endif

    state_t           state;
    logic [FRAME-1:0] asm_q;
    logic [FRAME-1:0] frame_next;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             ctr_clr;
    logic             ctr_ld1;
    logic             ctr_inc;
    logic             accept;
    logic             out_free;
    logic             sof_resync;
    logic             par_fill;
    logic             par_stall;

    assign accept     = din_valid & din_ready;
    assign out_free   = !y_valid | y_ready;
    assign sof_resync = accept & sof & (state == FILL) & (cnt != '0);

    // Frame as it will look once the bit being accepted is written.
    always_comb begin
        frame_next      = asm_q;
        frame_next[cnt] = din;
    end

    // Parity check result for a load straight from FILL or out of STALL.
    always_comb begin
`ifdef DEMUX_PARITY_EN
        par_fill  = xor_reduce(64'(frame_next));
        par_stall = xor_reduce(64'(asm_q));
`else
        par_fill  = 1'b0;
        par_stall = 1'b0;
`endif
    end

    // Slot counter controls; a completed frame always rewinds to slot 0,
    // so sel already points at slot 0 while stalled.
    always_comb begin
        ctr_clr = 1'b0;
        ctr_ld1 = 1'b0;
        ctr_inc = 1'b0;
        case (state)
            IDLE: begin
                if (accept && sof) ctr_ld1 = 1'b1;
            end
            FILL: begin
                if (accept) begin
                    if (sof_resync) ctr_ld1 = 1'b1;
                    else if (tc)    ctr_clr = 1'b1;
                    else            ctr_inc = 1'b1;
                end
            end
            STALL: begin
                if (out_free) ctr_clr = 1'b1;
            end
            default: ctr_clr = 1'b1;
        endcase
    end

    demux_slot_ctr #(
        .W    (CW),
        .LAST (FRAME - 1)
    ) u_slot_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .ld1 (ctr_ld1),
        .inc (ctr_inc),
        .cnt (cnt),
        .tc  (tc)
    );

    assign sel = cnt[SEL_W-1:0];

    // Frame FSM with assembly/output registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            din_ready  <= 1'b1;
            asm_q      <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            sync_err   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            // A drain without a load empties the output; a load below overrides.
            if (y_ready) y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && sof) begin
                        asm_q <= {{(FRAME-1){1'b0}}, din};
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (sof_resync) begin
                            asm_q    <= {{(FRAME-1){1'b0}}, din};
                            sync_err <= 1'b1;
                        end else begin
                            asm_q <= frame_next;
                            if (tc) begin
                                if (out_free) begin
                                    y          <= frame_next[LANES-1:0];
                                    y_valid    <= 1'b1;
                                    parity_err <= par_fill;
                                end else begin
                                    state     <= STALL;
                                    din_ready <= 1'b0;
                                end
                            end
                        end
                    end
                end
                STALL: begin
                    if (out_free) begin
                        y          <= asm_q[LANES-1:0];
                        y_valid    <= 1'b1;
                        parity_err <= par_stall;
                        state      <= FILL;
                        din_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    din_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1x8_tdm.sv
// Self-checking bench for demux_1x8_tdm: directed scenarios plus a
// randomized run scored against a frame-queue reference model.
module tb_demux_1x8_tdm;

    localparam int LANES = 8;
`ifdef DEMUX_PARITY_EN
    localparam int FRAME  = LANES + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FRAME  = LANES;
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             sof;
    logic             din_ready;
    logic [2:0]       sel;
    logic [LANES-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             sync_err;
    logic             parity_err;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    demux_1x8_tdm dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .din_ready  (din_ready),
        .sel        (sel),
        .y          (y),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .sync_err   (sync_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Serial image of a frame: data bits in slot order, then the parity bit when enabled.
    function automatic logic [FRAME-1:0] make_frame(input logic [7:0] d, input logic pbit);
        logic [FRAME-1:0] f;
        f = '0;
        f[LANES-1:0] = d;
`ifdef DEMUX_PARITY_EN
        f[FRAME-1] = pbit;
`endif
        return f;
    endfunction

    task automatic drive(input logic v, input logic b, input logic s);
        din_valid = v; din = b; sof = s;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; sof = 1'b0; y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected %h", y, 8'h00); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        logic [7:0] d;
        logic [FRAME-1:0] f;
        int early;
        d = 8'b0100_1101;
        f = make_frame(d, ^d);
        early = 0;
        y_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            drive(1'b1, f[i], i == 0);
            if (i < FRAME - 1 && y_valid !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL first_early_valid: got %0d early pulses expected 0", early); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL first_y_valid: got %b expected 1", y_valid); end
        checks++; if (y !== d) begin errors++; $display("FAIL first_y: got %b expected %b", y, d); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL first_parity: got %b expected 0", parity_err); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL first_pulse_len: y_valid got %b expected 0", y_valid); end
        checks++; if (y !== d) begin errors++; $display("FAIL first_y_hold: got %b expected %b", y, d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [3];
        logic [FRAME-1:0] f;
        int at [3];
        int seen, drops, serr;
        data[0] = 8'hA5; data[1] = 8'h3C; data[2] = 8'hFF;
        seen = 0; drops = 0; serr = 0;
        at[0] = 0; at[1] = 0; at[2] = 0;
        y_ready = 1'b1;
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL b2b_start_sel: got %0d expected 0", sel); end
        for (int k = 0; k < 3; k++) begin
            f = make_frame(data[k], ^data[k]);
            for (int i = 0; i < FRAME; i++) begin
                drive(1'b1, f[i], (k == 0) && (i == 0));
                if (din_ready !== 1'b1) drops++;
                if (sync_err !== 1'b0) serr++;
                if (y_valid === 1'b1 && seen < 3) begin
                    checks++;
                    if (y !== data[seen]) begin errors++; $display("FAIL b2b_y%0d: got %h expected %h", seen, y, data[seen]); end
                    at[seen] = cycle_cnt;
                    seen++;
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (seen !== 3) begin errors++; $display("FAIL b2b_count: got %0d frames expected 3", seen); end
        checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_din_ready: got %0d drops expected 0", drops); end
        checks++; if (serr !== 0) begin errors++; $display("FAIL b2b_sync_err: got %0d pulses expected 0", serr); end
        checks++; if (at[1] - at[0] !== FRAME) begin errors++; $display("FAIL b2b_gap01: got %0d expected %0d", at[1] - at[0], FRAME); end
        checks++; if (at[2] - at[1] !== FRAME) begin errors++; $display("FAIL b2b_gap12: got %0d expected %0d", at[2] - at[1], FRAME); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: y_valid got %b expected 0", y_valid); end
    endtask

    task automatic test_stall();
        logic [7:0] d1, d2;
        logic [FRAME-1:0] f;
        int drops;
        d1 = 8'($urandom); d2 = 8'($urandom) ^ 8'h5A;
        if (d2 == d1) d2 = ~d1;
        drops = 0;
        y_ready = 1'b0;
        f = make_frame(d1, ^d1);
        for (int i = 0; i < FRAME; i++) drive(1'b1, f[i], 1'b0);
        checks++; if (y_valid !== 1'b1 || y !== d1) begin errors++; $display("FAIL stall_first: y=%h v=%b expected y=%h v=1", y, y_valid, d1); end
        f = make_frame(d2, ^d2);
        for (int i = 0; i < FRAME; i++) begin
            if (din_ready !== 1'b1) drops++;
            drive(1'b1, f[i], 1'b0);
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL stall_early_drop: got %0d expected 0", drops); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL stall_din_ready: got %b expected 0", din_ready); end
        checks++; if (y !== d1 || y_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: y=%h v=%b expected y=%h v=1", y, y_valid, d1); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL stall_sel: got %0d expected 0", sel); end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        checks++; if (din_ready !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL stall_ignore_sof: rdy=%b serr=%b expected 0 0", din_ready, sync_err); end
        checks++; if (y !== d1) begin errors++; $display("FAIL stall_hold2: got %h expected %h", y, d1); end
        y_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (y !== d2 || y_valid !== 1'b1) begin errors++; $display("FAIL stall_release: y=%h v=%b expected y=%h v=1", y, y_valid, d2); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b expected 1", din_ready); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL stall_parity: got %b expected 0", parity_err); end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", y_valid); end
    endtask

    task automatic test_sync_err();
        logic [7:0] dn;
        logic [FRAME-1:0] f;
        int pulses;
        dn = 8'($urandom) | 8'h01;
        pulses = 0;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 1'b0);
        checks++; if (sel !== 3'd4) begin errors++; $display("FAIL sync_sel4: got %0d expected 4", sel); end
        f = make_frame(dn, ^dn);
        drive(1'b1, f[0], 1'b1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_pulse: got %b expected 1", sync_err); end
        checks++; if (sel !== 3'd1) begin errors++; $display("FAIL sync_sel1: got %0d expected 1", sel); end
        for (int i = 1; i < FRAME; i++) begin
            drive(1'b1, f[i], 1'b0);
            if (sync_err === 1'b1) pulses++;
            if (i < FRAME - 1 && y_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL sync_extra: got %0d extra events expected 0", pulses); end
        checks++; if (y_valid !== 1'b1 || y !== dn) begin errors++; $display("FAIL sync_frame: y=%h v=%b expected y=%h v=1", y, y_valid, dn); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] cur_d, exp_d;
        logic [FRAME-1:0] cur_f;
        int idx, frames, cyc;
        idx = 0; frames = 0; cyc = 0;
        cur_d = 8'($urandom); cur_f = make_frame(cur_d, ^cur_d);
        while (frames < 30 && cyc < 4000) begin
            @(posedge clk); #1;
            din_valid = ($urandom_range(0, 3) != 0);
            din = cur_f[idx];
            sof = (idx == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            y_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rand_sync_err: got %b expected 0", sync_err); end
            if (y_valid === 1'b1 && y_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got y=%h with no frame pending", y);
                end else begin
                    exp_d = q.pop_front();
                    if (y !== exp_d || parity_err !== 1'b0) begin
                        errors++; $display("FAIL rand_frame: got y=%h perr=%b expected y=%h perr=0", y, parity_err, exp_d);
                    end
                end
            end
            if (din_valid === 1'b1 && din_ready === 1'b1) begin
                idx++;
                if (idx == FRAME) begin
                    q.push_back(cur_d);
                    frames++;
                    idx = 0;
                    cur_d = 8'($urandom); cur_f = make_frame(cur_d, ^cur_d);
                end
            end
            cyc++;
        end
        checks++; if (frames < 30) begin errors++; $display("FAIL rand_budget: got %0d frames expected 30", frames); end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            din_valid = 1'b0; sof = 1'b0; y_ready = 1'b1;
            @(negedge clk);
            if (y_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_drain: got y=%h with no frame pending", y);
                end else begin
                    exp_d = q.pop_front();
                    if (y !== exp_d) begin errors++; $display("FAIL rand_drain: got %h expected %h", y, exp_d); end
                end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d undelivered frames expected 0", q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        logic [FRAME-1:0] f;
        logic exp1, exp0;
        int t1, t0;
        exp1 = PAR_EN & ((^8'h81) ^ 1'b1);
        exp0 = PAR_EN & ((^8'h81) ^ 1'b0);
        t1 = 0; t0 = 0;
        rst = 1'b1; drive(1'b0, 1'b0, 1'b0); rst = 1'b0;
        y_ready = 1'b1;
        f = make_frame(8'h81, 1'b1);
        for (int i = 0; i < FRAME; i++) drive(1'b1, f[i], i == 0);
        t1 = cycle_cnt;
        checks++; if (y !== 8'h81 || y_valid !== 1'b1) begin errors++; $display("FAIL par1_frame: y=%h v=%b expected y=81 v=1", y, y_valid); end
        checks++; if (parity_err !== exp1) begin errors++; $display("FAIL par1_err: got %b expected %b", parity_err, exp1); end
        f = make_frame(8'h81, 1'b0);
        for (int i = 0; i < FRAME; i++) drive(1'b1, f[i], 1'b0);
        t0 = cycle_cnt;
        checks++; if (parity_err !== exp0 || y_valid !== 1'b1) begin errors++; $display("FAIL par0_err: perr=%b v=%b expected perr=%b v=1", parity_err, y_valid, exp0); end
        checks++; if (t0 - t1 !== FRAME) begin errors++; $display("FAIL par_spacing: got %0d expected %0d", t0 - t1, FRAME); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_and_reset();
        int bad;
        bad = 0;
        y_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL rst_sel5: got %0d expected 5", sel); end
        checks++; if (y === 8'h00) begin errors++; $display("FAIL rst_precond: y got %h expected nonzero before reset", y); end
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_y: y=%h v=%b expected y=00 v=0", y, y_valid); end
        checks++; if (sel !== 3'd0 || din_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctl: sel=%0d rdy=%b expected 0 1", sel, din_ready); end
        checks++; if (sync_err !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: serr=%b perr=%b expected 0 0", sync_err, parity_err); end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'($urandom), 1'b0);
            if (y_valid !== 1'b0 || sel !== 3'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_drop: got %0d bad cycles expected 0", bad); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_stall();
        test_sync_err();
        test_random();
        test_parity();
        test_idle_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
